// File: rtl/leaf_packet_dispatch_pkg.sv
// Shared constants for the leaf packet dispatcher: command codes and port map.
package leaf_packet_dispatch_pkg;

    typedef enum logic [1:0] {
        CMD_CFG       = 2'd0,
        CMD_INSTR     = 2'd1,
        CMD_SET_START = 2'd2,
        CMD_CLR_START = 2'd3
    } cmd_e;

    localparam int PORT_INSTR    = 0;
    localparam int PORT_CFG      = 1;
    localparam int FIRST_IN_PORT = 2;

endpackage

// File: rtl/leaf_packet_dispatch_pkt_fifo.sv
// First-word-fall-through packet FIFO with extra-MSB pointers; pushes to a full FIFO are dropped.
module pkt_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Handshake: a word leaves on the edge where o_valid and i_ready are both high;
    // fullness is judged on the pre-pop state, so a push into a full FIFO is dropped.
    assign w_pop   = !w_empty && i_ready;
    assign w_wr    = i_push && !w_full;
    assign o_drop  = i_push && w_full;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/leaf_packet_dispatch.sv
// Leaf interface: decodes BFT packets into config, instruction, start control and
// per-channel stream FIFOs; outbound traffic and resend pass straight through.
module leaf_packet_dispatch
    import leaf_packet_dispatch_pkg::*;
#(
    parameter int PACKET_BITS     = 97,
    parameter int PAYLOAD_BITS    = 64,
    parameter int NUM_LEAF_BITS   = 6,
    parameter int NUM_PORT_BITS   = 4,
    parameter int NUM_IN_CH       = 7,
    parameter int FIFO_DEPTH      = 4,
    parameter int INSTR_ADDR_BITS = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PACKET_BITS-1:0]           din_leaf_bft2interface,
    input  logic                             resend,
    input  logic [PACKET_BITS-1:0]           stream_in,
    output logic [PACKET_BITS-1:0]           dout_leaf_interface2bft,
    output logic                             resend_out,
    output logic [PACKET_BITS-1:0]           configure_out,
    output logic [NUM_IN_CH*PACKET_BITS-1:0] ch_data,
    output logic [NUM_IN_CH-1:0]             ch_valid,
    input  logic [NUM_IN_CH-1:0]             ch_ready,
    output logic [31:0]                      instr_packet,
    output logic [INSTR_ADDR_BITS-1:0]       instr_addr,
    output logic                             instr_wr_en,
    output logic                             ap_start_user,
    output logic [15:0]                      drop_count
);
    localparam int PORT_LSB = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS;
    localparam logic [NUM_PORT_BITS-1:0] P_INSTR = NUM_PORT_BITS'(PORT_INSTR);
    localparam logic [NUM_PORT_BITS-1:0] P_FIRST = NUM_PORT_BITS'(FIRST_IN_PORT);
    localparam logic [NUM_PORT_BITS-1:0] P_LAST  = NUM_PORT_BITS'(FIRST_IN_PORT + NUM_IN_CH - 1);

    logic                     w_vld;
    logic [NUM_PORT_BITS-1:0] w_port;
    cmd_e                     w_cmd;
    logic                     w_is_ch;
    logic                     w_cfg;
    logic                     w_instr;
    logic                     w_set;
    logic                     w_clr;
    logic [NUM_IN_CH-1:0]     w_push;
    logic [NUM_IN_CH-1:0]     w_fifo_drop;

    logic [PACKET_BITS-1:0]     r_cfg;
    logic [31:0]                r_instr_packet;
    logic [INSTR_ADDR_BITS-1:0] r_instr_addr;
    logic [INSTR_ADDR_BITS-1:0] r_addr_cnt;
    logic                       r_instr_wr_en;
    logic                       r_start;
    logic [15:0]                r_drop_count;

    assign w_vld   = din_leaf_bft2interface[PACKET_BITS-1];
    assign w_port  = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    assign w_cmd   = cmd_e'(din_leaf_bft2interface[PAYLOAD_BITS +: 2]);
    assign w_is_ch = (w_port >= P_FIRST) && (w_port <= P_LAST);

    // Config covers every non-stream port, including the instruction port on CMD_CFG.
    assign w_cfg   = w_vld && (w_cmd == CMD_CFG) && !w_is_ch;
    assign w_instr = w_vld && (w_port == P_INSTR) && (w_cmd == CMD_INSTR);
    assign w_set   = w_vld && (w_port == P_INSTR) && (w_cmd == CMD_SET_START);
    assign w_clr   = w_vld && (w_port == P_INSTR) && (w_cmd == CMD_CLR_START);

    assign dout_leaf_interface2bft = stream_in;
    assign resend_out              = resend;

    for (genvar k = 0; k < NUM_IN_CH; k++) begin : g_ch
        assign w_push[k] = w_vld && (w_port == NUM_PORT_BITS'(FIRST_IN_PORT + k));

        pkt_fifo #(
            .WIDTH (PACKET_BITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[k]),
            .i_data  (din_leaf_bft2interface),
            .i_ready (ch_ready[k]),
            .o_data  (ch_data[k*PACKET_BITS +: PACKET_BITS]),
            .o_valid (ch_valid[k]),
            .o_drop  (w_fifo_drop[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg          <= '0;
            r_instr_packet <= '0;
            r_instr_addr   <= '0;
            r_addr_cnt     <= '0;
            r_instr_wr_en  <= 1'b0;
            r_start        <= 1'b0;
            r_drop_count   <= '0;
        end else begin
            r_cfg          <= w_cfg ? din_leaf_bft2interface : '0;
            r_instr_wr_en  <= w_instr;
            r_instr_packet <= w_instr ? din_leaf_bft2interface[31:0] : 32'd0;
            if (w_instr) begin
                r_instr_addr <= r_addr_cnt;
                r_addr_cnt   <= r_addr_cnt + 1'b1;
            end
            if (w_set) r_start <= 1'b1;
            if (w_clr) begin
                r_start    <= 1'b0;
                r_addr_cnt <= '0;
            end
            if ((|w_fifo_drop) && (r_drop_count != 16'hFFFF))
                r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign configure_out = r_cfg;
    assign instr_packet  = r_instr_packet;
    assign instr_addr    = r_instr_addr;
    assign instr_wr_en   = r_instr_wr_en;
    assign ap_start_user = r_start;
    assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_leaf_packet_dispatch.sv
// Randomized bench for leaf_packet_dispatch against a queue-level behavioural model.
module tb_leaf_packet_dispatch;
  localparam int PB   = 97;
  localparam int PL   = 64;
  localparam int LB   = 6;
  localparam int NPB  = 4;
  localparam int NCH  = 7;
  localparam int FD   = 4;
  localparam int IAB  = 12;
  localparam int PLSB = PB - 1 - LB - NPB;
  localparam int GAP  = PLSB - PL - 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [PB-1:0]       din = '0;
  logic                resend = 1'b0;
  logic [PB-1:0]       stream_in = '0;
  logic [PB-1:0]       dout;
  logic                resend_out;
  logic [PB-1:0]       configure_out;
  logic [NCH*PB-1:0]   ch_data;
  logic [NCH-1:0]      ch_valid;
  logic [NCH-1:0]      ch_ready = '0;
  logic [31:0]         instr_packet;
  logic [IAB-1:0]      instr_addr;
  logic                instr_wr_en;
  logic                ap_start_user;
  logic [15:0]         drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  leaf_packet_dispatch #(
    .PACKET_BITS(PB), .PAYLOAD_BITS(PL), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(NPB),
    .NUM_IN_CH(NCH), .FIFO_DEPTH(FD), .INSTR_ADDR_BITS(IAB)
  ) dut (
    .clk(clk), .reset(reset), .din_leaf_bft2interface(din), .resend(resend),
    .stream_in(stream_in), .dout_leaf_interface2bft(dout), .resend_out(resend_out),
    .configure_out(configure_out), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .instr_packet(instr_packet), .instr_addr(instr_addr),
    .instr_wr_en(instr_wr_en), .ap_start_user(ap_start_user), .drop_count(drop_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker helper ----------------
  function automatic void chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [PB-1:0]  mq [NCH][FD];
  int             mcnt [NCH];
  logic [PB-1:0]  exp_cfg = '0;
  logic           exp_wr = 1'b0;
  logic [31:0]    exp_ipk = '0;
  int             exp_iaddr = 0;
  int             m_cnt = 0;
  logic           exp_start = 1'b0;
  int             exp_drop = 0;
  bit             m_v;
  int             m_p, m_c, m_tgt;
  bit             m_full;

  initial for (int k = 0; k < NCH; k++) mcnt[k] = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) mcnt[k] = 0;
      exp_cfg = '0; exp_wr = 1'b0; exp_ipk = '0; exp_iaddr = 0;
      m_cnt = 0; exp_start = 1'b0; exp_drop = 0;
    end else begin
      m_v   = din[PB-1];
      m_p   = int'(din[PLSB +: NPB]);
      m_c   = int'(din[PL +: 2]);
      m_tgt = (m_v && m_p >= 2 && m_p <= NCH + 1) ? m_p - 2 : -1;
      m_full = (m_tgt >= 0) && (mcnt[m_tgt] == FD);
      for (int k = 0; k < NCH; k++) begin
        if (mcnt[k] > 0 && ch_ready[k]) begin
          for (int j = 0; j < FD - 1; j++) mq[k][j] = mq[k][j+1];
          mcnt[k]--;
        end
      end
      if (m_tgt >= 0) begin
        if (m_full) begin
          if (exp_drop < 65535) exp_drop++;
        end else begin
          mq[m_tgt][mcnt[m_tgt]] = din;
          mcnt[m_tgt]++;
        end
      end
      exp_cfg = (m_v && m_c == 0 && m_tgt < 0) ? din : '0;
      exp_wr  = m_v && m_p == 0 && m_c == 1;
      exp_ipk = exp_wr ? din[31:0] : 32'd0;
      if (exp_wr) begin
        exp_iaddr = m_cnt;
        m_cnt = (m_cnt + 1) % (1 << IAB);
      end
      if (m_v && m_p == 0 && m_c == 2) exp_start = 1'b1;
      if (m_v && m_p == 0 && m_c == 3) begin
        exp_start = 1'b0;
        m_cnt = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("dout", dout, stream_in);
    chk("resend_out", PB'(resend_out), PB'(resend));
    chk("configure_out", configure_out, exp_cfg);
    chk("instr_wr_en", PB'(instr_wr_en), PB'(exp_wr));
    chk("instr_packet", PB'(instr_packet), PB'(exp_ipk));
    if (exp_wr) chk("instr_addr", PB'(instr_addr), PB'(exp_iaddr));
    chk("ap_start_user", PB'(ap_start_user), PB'(exp_start));
    chk("drop_count", PB'(drop_count), PB'(exp_drop));
    for (int k = 0; k < NCH; k++) begin
      chk("ch_valid", PB'(ch_valid[k]), PB'(mcnt[k] > 0));
      if (mcnt[k] > 0) chk("ch_data", ch_data[k*PB +: PB], mq[k][0]);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [PB-1:0] mk_pkt(input bit v, input int port, input int cmd, input logic [PL-1:0] pl);
    logic [PB-1:0] p;
    p = '0;
    p[PB-1]            = v;
    p[PLSB+NPB +: LB]  = LB'($urandom);
    p[PLSB +: NPB]     = NPB'(port);
    p[PL+2 +: GAP]     = GAP'($urandom);
    p[PL +: 2]         = 2'(cmd);
    p[PL-1:0]          = pl;
    return p;
  endfunction

  function automatic logic [PL-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic [PB-1:0] pkt, input logic [NCH-1:0] rdy);
    din       = pkt;
    ch_ready  = rdy;
    stream_in = PB'({$urandom, $urandom, $urandom, $urandom});
    resend    = 1'($urandom);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) drive(mk_pkt(1, 2, 0, rnd64()), '0);
    reset = 1'b0;
  endtask

  logic [PB-1:0] idle;
  logic [PB-1:0] pk;
  logic [PB-1:0] pk_q [5];

  initial begin
    idle = '0;
    do_reset(2);
    // reset state
    chk("rst_cfg", configure_out, '0);
    chk("rst_instr_addr", PB'(instr_addr), '0);
    chk("rst_start", PB'(ap_start_user), '0);
    chk("rst_drop", PB'(drop_count), '0);
    chk("rst_valid", PB'(ch_valid), '0);

    // port 3 packet lands in channel 1
    pk = mk_pkt(1, 3, 0, 64'hA5);
    drive(pk, '0);
    chk("p3_valid", PB'(ch_valid), PB'(7'b0000010));
    chk("p3_data", ch_data[1*PB +: PB], pk);
    chk("p3_cfg", configure_out, '0);
    do_reset(1);

    // overflow of channel 0 then drain in order
    for (int i = 0; i < 5; i++) begin
      pk_q[i] = mk_pkt(1, 2, $urandom_range(0, 3), rnd64());
      drive(pk_q[i], '0);
    end
    chk("ovf_drop", PB'(drop_count), PB'(1));
    chk("ovf_head", ch_data[0 +: PB], pk_q[0]);
    for (int i = 1; i < 4; i++) begin
      drive(idle, 7'b0000001);
      chk("drain_head", ch_data[0 +: PB], pk_q[i]);
    end
    drive(idle, 7'b0000001);
    chk("drain_empty", PB'(ch_valid[0]), '0);

    // instruction writes and address clear
    drive(mk_pkt(1, 0, 1, 64'h13), '0);
    chk("i0_addr", PB'(instr_addr), PB'(0));
    chk("i0_pkt", PB'(instr_packet), PB'(32'h13));
    drive(mk_pkt(1, 0, 1, 64'h93), '0);
    chk("i1_addr", PB'(instr_addr), PB'(1));
    drive(mk_pkt(1, 0, 3, 64'h0), '0);
    chk("clr_wr", PB'(instr_wr_en), '0);
    drive(mk_pkt(1, 0, 1, 64'h33), '0);
    chk("i2_addr", PB'(instr_addr), PB'(0));
    chk("i2_pkt", PB'(instr_packet), PB'(32'h33));
    chk("i2_start", PB'(ap_start_user), '0);

    // start level hold and clear
    drive(mk_pkt(1, 0, 2, rnd64()), '0);
    for (int i = 0; i < 10; i++) begin
      drive(idle, '0);
      chk("start_hold", PB'(ap_start_user), PB'(1));
    end
    drive(mk_pkt(1, 0, 3, rnd64()), '0);
    chk("start_clr", PB'(ap_start_user), '0);

    // config port 9
    pk = mk_pkt(1, 9, 0, rnd64());
    drive(pk, '0);
    chk("cfg9", configure_out, pk);
    drive(idle, '0);
    chk("cfg9_clr", configure_out, '0);
    drive(mk_pkt(1, 9, 1, rnd64()), '0);
    chk("cfg9_cmd1", configure_out, '0);

    // mid-stream reset flush
    for (int i = 0; i < 3; i++) drive(mk_pkt(1, 2, 0, rnd64()), '0);
    chk("pre_rst_valid", PB'(ch_valid[0]), PB'(1));
    do_reset(1);
    chk("flush_valid", PB'(ch_valid), '0);
    chk("flush_drop", PB'(drop_count), '0);
    pk = mk_pkt(1, 2, 1, rnd64());
    drive(pk, '0);
    chk("post_rst_valid", PB'(ch_valid[0]), PB'(1));
    chk("post_rst_data", ch_data[0 +: PB], pk);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        pk = mk_pkt($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3), rnd64());
        drive(pk, NCH'($urandom) | ($urandom_range(0, 2) == 0 ? NCH'(0) : NCH'($urandom)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
